// File: rtl/score_disp_pkg.sv
// Shared constants for the score glyph renderer: pixel port widths, glyph geometry,
// FSM state encoding and the glyph bit addressing helper.
package score_disp_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam int GLYPH_W    = 3;
  localparam int GLYPH_H    = 5;
  localparam int GLYPH_BITS = 15;

  localparam logic [GLYPH_BITS-1:0] ZERO_GLYPH = 15'b111101101101111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SNAP   = 3'd2;
  localparam logic [2:0] ST_DRAW   = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  // Glyph bit for row r (top-down), column c (left-right).
  function automatic logic [3:0] glyph_index(input logic [2:0] r, input logic [1:0] c);
    return ({1'b0, r} * 4'd3) + {2'b00, c};
  endfunction

endpackage

// File: rtl/score_render_ctrl_if.sv
// Pixel plot port between the score renderer (master) and the VGA adapter (slave).
interface score_render_ctrl_if;
  import score_disp_pkg::*;

  logic                plot;
  logic                plot_ready;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;

  modport master (output plot, output x, output y, output colour, input plot_ready);
  modport slave  (input plot, input x, input y, input colour, output plot_ready);

endinterface

// File: rtl/render_scan_counter.sv
// Nested digit/row/col pixel counter (col fastest). Exposes the current position and
// the position it would move to on the next advance.
module render_scan_counter
  import score_disp_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic       d_o,
  output logic [2:0] r_o,
  output logic [1:0] c_o,
  output logic [3:0] idx_o,
  output logic       last_o,
  output logic       d_nxt_o,
  output logic [2:0] r_nxt_o,
  output logic [1:0] c_nxt_o,
  output logic [3:0] idx_nxt_o
);

  logic       d_q, d_d;
  logic [2:0] r_q, r_d;
  logic [1:0] c_q, c_d;

  // Successor position in digit/row/col scan order.
  always_comb begin
    d_d = d_q;
    r_d = r_q;
    c_d = c_q;
    if (c_q == 2'(GLYPH_W - 1)) begin
      c_d = 2'd0;
      if (r_q == 3'(GLYPH_H - 1)) begin
        r_d = 3'd0;
        d_d = ~d_q;
      end else begin
        r_d = r_q + 3'd1;
      end
    end else begin
      c_d = c_q + 2'd1;
    end
  end

  // Position register: cleared before each scan, stepped only on advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q <= 1'b0;
      r_q <= 3'd0;
      c_q <= 2'd0;
    end else if (clr_i) begin
      d_q <= 1'b0;
      r_q <= 3'd0;
      c_q <= 2'd0;
    end else if (adv_i) begin
      d_q <= d_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign d_o       = d_q;
  assign r_o       = r_q;
  assign c_o       = c_q;
  assign idx_o     = glyph_index(r_q, c_q);
  assign last_o    = d_q && (r_q == 3'(GLYPH_H - 1)) && (c_q == 2'(GLYPH_W - 1));
  assign d_nxt_o   = d_d;
  assign r_nxt_o   = r_d;
  assign c_nxt_o   = c_d;
  assign idx_nxt_o = glyph_index(r_d, c_d);

endmodule

// File: rtl/score_render_ctrl.sv
// Turns a two-digit score glyph map into 30 handshaked pixel plots for the VGA adapter.
// Optional feature macro: SCORE_BLANK_LEAD_ZERO_EN (tens digit "0" drawn in background colour).
module score_render_ctrl
  import score_disp_pkg::*;
#(
  parameter logic [X_W-1:0]      X0            = 8'd4,
  parameter logic [Y_W-1:0]      Y0            = 7'd2,
  parameter logic [X_W-1:0]      DIGIT_PITCH   = 8'd4,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [COLOUR_W-1:0] FG_COLOUR     = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [6:0]                 score,
  input  logic [2*GLYPH_BITS-1:0]    map,
  input  logic                       start,
  score_render_ctrl_if.master        pif,
  output logic                       busy,
  output logic                       done
);

  logic [2:0]                  state_q, state_d;
  logic [7:0]                  settle_q, settle_d;
  logic                        pending_q, pending_d;
  logic [2*GLYPH_BITS-1:0]     snap_q, snap_d;
  logic [6:0]                  last_score_q, last_score_d;
  logic                        plot_q, plot_d;
  logic [X_W-1:0]              x_q, x_d;
  logic [Y_W-1:0]              y_q, y_d;
  logic [COLOUR_W-1:0]         colour_q, colour_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic       trigger_s, clr_s, adv_s;
  logic       d_s, d_nxt_s, last_s;
  logic [2:0] r_s, r_nxt_s;
  logic [1:0] c_s, c_nxt_s;
  logic [3:0] idx_s, idx_nxt_s;

  render_scan_counter u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (clr_s),
    .adv_i     (adv_s),
    .d_o       (d_s),
    .r_o       (r_s),
    .c_o       (c_s),
    .idx_o     (idx_s),
    .last_o    (last_s),
    .d_nxt_o   (d_nxt_s),
    .r_nxt_o   (r_nxt_s),
    .c_nxt_o   (c_nxt_s),
    .idx_nxt_o (idx_nxt_s)
  );

  function automatic logic [COLOUR_W-1:0] pix_colour(input logic [2*GLYPH_BITS-1:0] snap,
                                                     input logic d, input logic [3:0] idx);
    logic [GLYPH_BITS-1:0] glyph;
    glyph = d ? snap[GLYPH_BITS-1:0] : snap[2*GLYPH_BITS-1:GLYPH_BITS];
`ifdef SCORE_BLANK_LEAD_ZERO_EN
    if (!d && (glyph == ZERO_GLYPH)) begin
      return BG_COLOUR;
    end else begin
      return glyph[idx] ? FG_COLOUR : BG_COLOUR;
    end
`else
    return glyph[idx] ? FG_COLOUR : BG_COLOUR;
`endif
  endfunction

  function automatic logic [X_W-1:0] pix_x(input logic d, input logic [1:0] c);
    return X0 + (d ? DIGIT_PITCH : 8'd0) + {6'd0, c};
  endfunction

  // Next state, trigger/pending bookkeeping and the plot output pipeline.
  always_comb begin
    trigger_s    = start || (score != last_score_q);
    state_d      = state_q;
    settle_d     = settle_q;
    pending_d    = pending_q;
    snap_d       = snap_q;
    last_score_d = trigger_s ? score : last_score_q;
    plot_d       = plot_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    clr_s        = 1'b0;
    adv_s        = 1'b0;

    if (trigger_s && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d  = ST_SETTLE;
          settle_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SNAP;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_SNAP: begin
        snap_d  = map;
        clr_s   = 1'b1;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // Outputs always show the pixel the counter points at; on acceptance they
        // are reloaded with the successor so a ready adapter gets one pixel per cycle.
        if (!plot_q) begin
          plot_d   = 1'b1;
          x_d      = pix_x(d_s, c_s);
          y_d      = Y0 + {4'd0, r_s};
          colour_d = pix_colour(snap_q, d_s, idx_s);
        end else if (pif.plot_ready) begin
          if (last_s) begin
            plot_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            adv_s    = 1'b1;
            x_d      = pix_x(d_nxt_s, c_nxt_s);
            y_d      = Y0 + {4'd0, r_nxt_s};
            colour_d = pix_colour(snap_q, d_nxt_s, idx_nxt_s);
          end
        end else begin
          plot_d = plot_q;
        end
      end
      ST_FIN: begin
        pending_d = 1'b0;
        if (pending_q || trigger_s) begin
          state_d  = ST_SETTLE;
          settle_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        plot_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      settle_q     <= 8'd0;
      pending_q    <= 1'b0;
      snap_q       <= '0;
      last_score_q <= 7'd0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      pending_q    <= pending_d;
      snap_q       <= snap_d;
      last_score_q <= last_score_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pif.plot   = plot_q;
  assign pif.x      = x_q;
  assign pif.y      = y_q;
  assign pif.colour = colour_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
